// File: rtl/hsv_thresh_ctrl.sv
// HSV threshold configuration controller: shadow/active threshold sets with
// frame-aligned commit, plus a saturating per-frame mask-hit counter.
module hsv_thresh_ctrl #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_commit,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic             pix_hit,
  output logic [7:0]       h_lo,
  output logic [7:0]       h_hi,
  output logic [7:0]       s_lo,
  output logic [7:0]       s_hi,
  output logic [7:0]       v_lo,
  output logic [7:0]       v_hi,
  output logic             commit_pending,
  output logic             commit_done,
  output logic             range_err,
  output logic             addr_err,
  output logic [CNT_W-1:0] hit_count,
  output logic             count_valid
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Element order is h_lo, h_hi, s_lo, s_hi, v_lo, v_hi (index 0..5).
  localparam logic [5:0][7:0] PASS_ALL = {3{8'hFF, 8'h00}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [5:0][7:0]  shadow_q, shadow_d;
  logic [5:0][7:0]  active_q, active_d;
  logic             commit_done_q, commit_done_d;
  logic             range_err_q, range_err_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             count_valid_q, count_valid_d;

  logic             wr_accept;
  logic             shadow_inverted;
  logic             pix_counted;

  assign cfg_ready      = (state_q == IDLE);
  assign commit_pending = (state_q == PENDING);
  assign wr_accept      = cfg_valid & cfg_ready;
  assign pix_counted    = pix_valid & pix_hit;

  assign shadow_inverted = (shadow_q[0] > shadow_q[1]) |
                           (shadow_q[2] > shadow_q[3]) |
                           (shadow_q[4] > shadow_q[5]);

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_done_d = 1'b0;
    range_err_d   = range_err_q;
    addr_err_d    = 1'b0;

    if (wr_accept) begin
      if (cfg_addr <= 3'd5) begin
        shadow_d[cfg_addr] = cfg_data;
      end else begin
        addr_err_d = 1'b1;
      end
    end

    // A commit seen in IDLE never applies on the same edge, even with
    // frame_start high; it always waits for a later frame boundary.
    unique case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          active_d      = shadow_q;
          range_err_d   = shadow_inverted;
          commit_done_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The hit coinciding with frame_start is the first hit of the new frame.
  always_comb begin
    cnt_d         = cnt_q;
    hit_count_d   = hit_count_q;
    count_valid_d = 1'b0;

    if (frame_start) begin
      hit_count_d   = cnt_q;
      cnt_d         = CNT_W'(pix_counted);
      count_valid_d = 1'b1;
    end else if (pix_counted && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_q      <= PASS_ALL;
      active_q      <= PASS_ALL;
      commit_done_q <= 1'b0;
      range_err_q   <= 1'b0;
      addr_err_q    <= 1'b0;
      cnt_q         <= '0;
      hit_count_q   <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      commit_done_q <= commit_done_d;
      range_err_q   <= range_err_d;
      addr_err_q    <= addr_err_d;
      cnt_q         <= cnt_d;
      hit_count_q   <= hit_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign h_lo        = active_q[0];
  assign h_hi        = active_q[1];
  assign s_lo        = active_q[2];
  assign s_hi        = active_q[3];
  assign v_lo        = active_q[4];
  assign v_hi        = active_q[5];
  assign commit_done = commit_done_q;
  assign range_err   = range_err_q;
  assign addr_err    = addr_err_q;
  assign hit_count   = hit_count_q;
  assign count_valid = count_valid_q;

endmodule

// File: tb/tb_hsv_thresh_ctrl.sv
// Self-checking bench for hsv_thresh_ctrl: directed scenarios plus randomized
// traffic, compared each cycle against a behavioural model of the controller.
module tb_hsv_thresh_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       cfg_commit = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_hit = 1'b0;

  logic        a_ready, a_pend, a_done, a_rerr, a_aerr, a_cv;
  logic [7:0]  a_hlo, a_hhi, a_slo, a_shi, a_vlo, a_vhi;
  logic [19:0] a_hc;
  logic        b_ready, b_pend, b_done, b_rerr, b_aerr, b_cv;
  logic [7:0]  b_hlo, b_hhi, b_slo, b_shi, b_vlo, b_vhi;
  logic [3:0]  b_hc;

  always #5 clk = ~clk;

  hsv_thresh_ctrl #(.CNT_W(20)) u_dut20 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(a_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_hit(pix_hit),
    .h_lo(a_hlo), .h_hi(a_hhi), .s_lo(a_slo), .s_hi(a_shi), .v_lo(a_vlo), .v_hi(a_vhi),
    .commit_pending(a_pend), .commit_done(a_done), .range_err(a_rerr),
    .addr_err(a_aerr), .hit_count(a_hc), .count_valid(a_cv)
  );

  hsv_thresh_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(b_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_hit(pix_hit),
    .h_lo(b_hlo), .h_hi(b_hhi), .s_lo(b_slo), .s_hi(b_shi), .v_lo(b_vlo), .v_hi(b_vhi),
    .commit_pending(b_pend), .commit_done(b_done), .range_err(b_rerr),
    .addr_err(b_aerr), .hit_count(b_hc), .count_valid(b_cv)
  );

  logic [131:0] dut_vec;
  assign dut_vec = {a_hlo, a_hhi, a_slo, a_shi, a_vlo, a_vhi,
                    a_ready, a_pend, a_done, a_rerr, a_aerr, a_cv, a_hc,
                    b_hlo, b_hhi, b_slo, b_shi, b_vlo, b_vhi,
                    b_ready, b_pend, b_done, b_rerr, b_aerr, b_cv, b_hc};

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  logic [7:0] m_sh [6];
  logic [7:0] m_act [6];
  logic       m_pend, m_done, m_rerr, m_aerr, m_cv;
  int         m_cnt, m_cnt4, m_hc, m_hc4;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_sh[i]  = (i % 2 == 0) ? 8'h00 : 8'hFF;
      m_act[i] = m_sh[i];
    end
    m_pend = 0; m_done = 0; m_rerr = 0; m_aerr = 0; m_cv = 0;
    m_cnt = 0; m_cnt4 = 0; m_hc = 0; m_hc4 = 0;
  endtask

  function automatic logic [131:0] exp_vec();
    logic [53:0] c;
    c = {m_act[0], m_act[1], m_act[2], m_act[3], m_act[4], m_act[5],
         ~m_pend, m_pend, m_done, m_rerr, m_aerr, m_cv};
    return {c, 20'(m_hc), c, 4'(m_hc4)};
  endfunction

  // Advance the model by one edge using the inputs currently driven, then
  // clock the DUT and release the single-cycle inputs at the falling edge.
  task automatic tick();
    bit accept, hit;
    accept = cfg_valid && !m_pend;
    hit    = pix_valid && pix_hit;
    m_aerr = accept && (cfg_addr >= 6);
    if (accept && cfg_addr < 6) m_sh[cfg_addr] = cfg_data;
    m_done = 0;
    if (m_pend && frame_start) begin
      for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
      m_rerr = (m_sh[0] > m_sh[1]) || (m_sh[2] > m_sh[3]) || (m_sh[4] > m_sh[5]);
      m_pend = 0;
      m_done = 1;
    end else if (!m_pend && cfg_commit) begin
      m_pend = 1;
    end
    if (frame_start) begin
      m_hc = m_cnt; m_hc4 = m_cnt4;
      m_cnt = hit ? 1 : 0; m_cnt4 = m_cnt;
      m_cv = 1;
    end else begin
      m_cv = 0;
      if (hit) begin
        m_cnt  = (m_cnt  < (1 << 20) - 1) ? m_cnt + 1  : m_cnt;
        m_cnt4 = (m_cnt4 < 15)            ? m_cnt4 + 1 : m_cnt4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 0; cfg_commit = 0; frame_start = 0; pix_valid = 0; pix_hit = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_valid = 1; cfg_addr = a; cfg_data = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_state got %h want %h", dut_vec, exp_vec());
    else passed++;
    checks++;
    if ({a_hlo, a_hhi, a_ready, a_rerr} !== {8'h00, 8'hFF, 1'b1, 1'b0})
      $display("FAIL reset_literal got %h want %h", {a_hlo, a_hhi, a_ready, a_rerr}, {8'h00, 8'hFF, 2'b10});
    else passed++;
    rst = 0;
    tick();
    frame_start = 1;
    tick();
    checks++;
    if ({a_hc, a_cv} !== {20'd0, 1'b1}) $display("FAIL first_frame_count got %h want %h", {a_hc, a_cv}, {20'd0, 1'b1});
    else passed++;
  endtask

  task automatic test_commit_basic();
    int bad;
    wr(3'd0, 8'd20);
    wr(3'd1, 8'd40);
    cfg_commit = 1;
    tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cfg_valid = 1; cfg_addr = 3'd0; cfg_data = 8'd99;
      end
      if (a_pend !== 1'b1 || a_ready !== 1'b0 || a_hlo !== 8'd0 || a_hhi !== 8'd255 || a_done !== 1'b0) bad++;
      if (dut_vec !== exp_vec()) bad++;
      tick();
    end
    checks++;
    if (bad != 0) $display("FAIL commit_wait got %0d bad cycles want 0", bad);
    else passed++;
    frame_start = 1;
    tick();
    checks++;
    if ({a_hlo, a_hhi, a_done, a_pend, a_ready} !== {8'd20, 8'd40, 3'b101})
      $display("FAIL commit_apply got %h want %h", {a_hlo, a_hhi, a_done, a_pend, a_ready}, {8'd20, 8'd40, 3'b101});
    else passed++;
    tick();
    checks++;
    if (a_done !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL commit_done_single got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_commit_same_frame();
    wr(3'd2, 8'd50);
    cfg_commit = 1; frame_start = 1;
    tick();
    checks++;
    if ({a_slo, a_pend, a_done} !== {8'd0, 1'b1, 1'b0})
      $display("FAIL same_cycle_noapply got %h want %h", {a_slo, a_pend, a_done}, {8'd0, 2'b10});
    else passed++;
    repeat (3) tick();
    frame_start = 1;
    tick();
    checks++;
    if ({a_slo, a_done} !== {8'd50, 1'b1}) $display("FAIL same_cycle_later got %h want %h", {a_slo, a_done}, {8'd50, 1'b1});
    else passed++;
  endtask

  task automatic test_addr_range_err();
    wr(3'd6, 8'h55);
    checks++;
    if (a_aerr !== 1'b1) $display("FAIL addr_err_pulse got %b want 1", a_aerr);
    else passed++;
    tick();
    checks++;
    if (a_aerr !== 1'b0) $display("FAIL addr_err_single got %b want 0", a_aerr);
    else passed++;
    cfg_commit = 1; tick();
    tick();
    frame_start = 1; tick();
    checks++;
    if ({a_hlo, a_hhi, a_slo, a_shi, a_vlo, a_vhi, a_rerr} !== {8'd20, 8'd40, 8'd50, 8'hFF, 8'h00, 8'hFF, 1'b0})
      $display("FAIL addr_err_unchanged got %h want %h", {a_hlo, a_hhi, a_slo, a_shi, a_vlo, a_vhi, a_rerr},
               {8'd20, 8'd40, 8'd50, 8'hFF, 8'h00, 8'hFF, 1'b0});
    else passed++;
    wr(3'd4, 8'd200);
    wr(3'd5, 8'd100);
    cfg_commit = 1; tick();
    frame_start = 1; tick();
    checks++;
    if ({a_vlo, a_vhi, a_rerr} !== {8'd200, 8'd100, 1'b1})
      $display("FAIL range_err got %h want %h", {a_vlo, a_vhi, a_rerr}, {8'd200, 8'd100, 1'b1});
    else passed++;
  endtask

  task automatic test_hit_count();
    int cv_seen;
    frame_start = 1; tick();
    for (int i = 0; i < 1000; i++) begin
      pix_valid = 1; pix_hit = (i % 10 < 3);
      tick();
    end
    frame_start = 1; pix_valid = 1; pix_hit = 1;
    tick();
    checks++;
    if ({a_hc, a_cv, b_hc, b_cv} !== {20'd300, 1'b1, 4'd15, 1'b1})
      $display("FAIL hit_count_300 got %h want %h", {a_hc, a_cv, b_hc, b_cv}, {20'd300, 1'b1, 4'd15, 1'b1});
    else passed++;
    cv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_cv) cv_seen++;
      tick();
    end
    checks++;
    if (cv_seen != 1) $display("FAIL count_valid_once got %0d want 1", cv_seen);
    else passed++;
    frame_start = 1; tick();
    checks++;
    if ({a_hc, b_hc} !== {20'd1, 4'd1}) $display("FAIL next_frame_start1 got %h want %h", {a_hc, b_hc}, {20'd1, 4'd1});
    else passed++;
  endtask

  task automatic test_reset_pending();
    wr(3'd3, 8'd77);
    cfg_commit = 1; tick();
    checks++;
    if (a_pend !== 1'b1) $display("FAIL pending_before_rst got %b want 1", a_pend);
    else passed++;
    rst = 1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) $display("FAIL async_reset got %h want %h", dut_vec, exp_vec());
    else passed++;
    @(negedge clk);
    rst = 0;
    tick();
    frame_start = 1; tick();
    checks++;
    if ({a_done, a_pend, a_shi} !== {1'b0, 1'b0, 8'hFF}) $display("FAIL no_done_after_rst got %h want %h", {a_done, a_pend, a_shi}, {2'b00, 8'hFF});
    else passed++;
    for (int i = 0; i < 20; i++) begin
      pix_valid = 1; pix_hit = 1; tick();
    end
    frame_start = 1; tick();
    checks++;
    if ({a_hc, b_hc} !== {20'd20, 4'd15}) $display("FAIL saturate_cnt4 got %h want %h", {a_hc, b_hc}, {20'd20, 4'd15});
    else passed++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      cfg_valid   = ($urandom_range(0, 1) == 1);
      cfg_addr    = 3'($urandom_range(0, 7));
      cfg_data    = 8'($urandom);
      cfg_commit  = ($urandom_range(0, 7) == 0);
      frame_start = ($urandom_range(0, 40) == 0);
      pix_valid   = ($urandom_range(0, 3) != 0);
      pix_hit     = ($urandom_range(0, 1) == 1);
      tick();
      if (dut_vec !== exp_vec()) begin
        bad++;
        if (bad <= 5) $display("FAIL random_cycle_%0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (bad != 0) $display("FAIL random_total got %0d bad cycles want 0", bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_commit_basic();
    test_commit_same_frame();
    test_addr_range_err();
    test_hit_count();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hsv_thresh_ctrl.md
Name: hsv_thresh_ctrl

Overview:
Configuration controller for the HSV colour-threshold stage of the image processing unit. It accepts threshold writes from the host/processor side into shadow registers and commits them to the active H/S/V low/high bounds only at a frame boundary, so no frame is ever masked with a mixed threshold set. It also counts per frame the pixels that passed the mask and reports that count, which gives the tracking logic a simple object-presence measure.

Parameters:
CNT_W, 20, width of the per-frame hit counter (saturating)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  write request
cfg_ready  out  1  controller can accept a write
cfg_addr  in  3  0=h_lo 1=h_hi 2=s_lo 3=s_hi 4=v_lo 5=v_hi; 6,7 invalid
cfg_data  in  8  threshold value
cfg_commit  in  1  single-cycle pulse; request apply of shadow set
frame_start  in  1  single-cycle pulse on first pixel of each frame
pix_valid  in  1  pixel strobe from mask stage
pix_hit  in  1  pixel passed all three masks (qualified by pix_valid)
h_lo, h_hi, s_lo, s_hi, v_lo, v_hi  out  8 each  active thresholds
commit_pending  out  1  high while waiting for frame_start to apply
commit_done  out  1  one-cycle pulse after active set updated
range_err  out  1  registered; any active lo > hi
addr_err  out  1  one-cycle pulse on write to addr 6/7
hit_count  out  CNT_W  hits counted in last completed frame
count_valid  out  1  one-cycle pulse when hit_count updates

Behaviour:
- Reset (async, immediate): state=IDLE; shadow and active lo=8'h00, hi=8'hFF (pass-all); cfg_ready=1; commit_pending, commit_done, range_err, addr_err, count_valid=0; hit_count=0; internal counter=0.
- Write handshake: transfer on rising edge when cfg_valid & cfg_ready. Addr 0-5 updates that shadow register; addr 6/7 changes nothing and pulses addr_err the next cycle. cfg_valid with cfg_ready=0 is ignored, not queued; the host holds it.
- State IDLE: cfg_ready=1. A cfg_commit moves the FSM to PENDING. This applies even if the same cycle carries a write: the write lands in the shadow set and is included in the commit.
- State PENDING: cfg_ready=0, commit_pending=1. Further cfg_commit is ignored. On an edge with frame_start=1: active <= shadow, range_err <= (any shadow lo > hi), state -> IDLE. commit_done=1 for the following cycle, during which the new thresholds are already visible on the outputs.
- cfg_commit and frame_start in the same IDLE cycle: enter PENDING; apply on the next frame_start, not this one. A commit therefore always waits for a strictly later frame boundary.
- An inverted range (lo > hi) is still applied. Downstream then masks everything for that channel, and range_err flags it.
- Hit counter:
  - Increments on pix_valid & pix_hit and saturates at 2^CNT_W-1.
  - On frame_start: hit_count <= the counter value including any hit in that same cycle only if it belongs to the old frame. Decided: the pixel coinciding with frame_start belongs to the new frame.
  - So on a frame_start edge, hit_count <= counter, counter <= (pix_valid & pix_hit), and count_valid pulses the next cycle.
  - The first frame_start after reset reports 0.
- Active threshold outputs are registered and change only on reset or on a commit edge.

Test Plan:
- Reset then idle: outputs read h/s/v_lo=0x00, hi=0xFF, cfg_ready=1, range_err=0.
- Write h_lo=20, h_hi=40, then cfg_commit; frame_start 10 cycles later -> h_lo/h_hi stay 0/255 until the frame_start edge, read 20/40 the next cycle; commit_done is a single pulse; commit_pending is high for exactly the waiting interval; cfg_ready is low during it.
- cfg_commit and frame_start in the same cycle with s_lo=50 written earlier -> no update at that frame_start; s_lo=50 appears after the next frame_start.
- Write addr 6 data 0x55 -> addr_err pulses one cycle; all shadow/active registers are unchanged after a subsequent commit; write v_lo=200, v_hi=100 and commit -> range_err=1 after apply.
- Frame of 1000 pix_valid with 300 pix_hit, plus a hit coinciding with the closing frame_start -> hit_count=300 and count_valid pulses once; the next frame's count starts at 1.
- Assert rst while PENDING -> state returns to IDLE immediately, thresholds return to pass-all, commit_pending=0, no commit_done on the following frame_start; with CNT_W=4 and 20 hits per frame -> hit_count=15.
